// File: rtl/ysyx_22040632_imif_axi_rd_bridge_if.sv
// ysyx_22040632_imif_axi_rd_bridge_if: icache request port and AXI4 read-channel bundles
interface ysyx_22040632_imif_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic              rw_valid;
    logic              rw_ready;
    logic              rw_req;
    logic [ADDR_W-1:0] rw_addr;
    logic [7:0]        rw_len;
    logic [2:0]        rw_size;
    logic [DATA_W-1:0] data_read;
    logic              r_hs;
    logic              r_last;
    logic              rw_err;
    modport master (
        output rw_valid, rw_req, rw_addr, rw_len, rw_size,
        input  rw_ready, data_read, r_hs, r_last, rw_err
    );
    modport slave (
        input  rw_valid, rw_req, rw_addr, rw_len, rw_size,
        output rw_ready, data_read, r_hs, r_last, rw_err
    );
endinterface

interface ysyx_22040632_axi_rd_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [3:0]        arid;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic [3:0]        rid;
    modport master (
        output arvalid, araddr, arlen, arsize, arburst, arid, rready,
        input  arready, rvalid, rdata, rresp, rlast, rid
    );
    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst, arid, rready,
        output arready, rvalid, rdata, rresp, rlast, rid
    );
endinterface

// File: rtl/ysyx_22040632_imif_axi_rd_bridge.sv
// ysyx_22040632_imif_axi_rd_bridge: turns one icache read request into an AXI4 AR/R burst
module ysyx_22040632_imif_axi_rd_bridge #(
    parameter logic [3:0] AXI_ID = 4'd0,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input logic clk,
    input logic rrst_n,
    ysyx_22040632_imif_if.slave imif,
    ysyx_22040632_axi_rd_if.master axi
);
    typedef enum logic [1:0] {IDLE, AR, R, WERR} state_t;
    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [7:0]        cnt;
    logic [2:0]        size;
    logic              arvalid;
    logic              rready;
    logic              err;
    logic              r_hs;
    logic              at_len;
    logic              beat_err;
    logic              done;
    assign r_hs     = axi.rvalid & rready;
    assign at_len   = cnt == len;
    // rlast and the beat count must agree; either one finishing early is a protocol error
    assign beat_err = (axi.rresp != 2'b00) | (axi.rid != AXI_ID) | (axi.rlast ^ at_len);
    assign done     = r_hs & (axi.rlast | at_len);
    assign axi.arvalid    = arvalid;
    assign axi.araddr     = addr;
    assign axi.arlen      = len;
    assign axi.arsize     = size;
    assign axi.arburst    = 2'b01;
    assign axi.arid       = AXI_ID;
    assign axi.rready     = rready;
    assign imif.r_hs      = r_hs;
    assign imif.r_last    = done;
    assign imif.rw_ready  = done | (state == WERR);
    assign imif.rw_err    = (done & (err | beat_err)) | (state == WERR);
    assign imif.data_read = !r_hs ? '0 : size < 3'd3 ? axi.rdata >> {addr[2:0], 3'b000} : axi.rdata;
    always_ff @(posedge clk or negedge rrst_n) begin
        if (!rrst_n) begin
            state   <= IDLE;
            addr    <= '0;
            len     <= '0;
            size    <= '0;
            cnt     <= '0;
            err     <= 1'b0;
            arvalid <= 1'b0;
            rready  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (imif.rw_valid) begin
                    if (imif.rw_req) state <= WERR;
                    else begin
                        addr    <= imif.rw_addr;
                        len     <= imif.rw_len;
                        size    <= imif.rw_size;
                        cnt     <= '0;
                        err     <= 1'b0;
                        arvalid <= 1'b1;
                        state   <= AR;
                    end
                end
                AR: if (axi.arready) begin
                    arvalid <= 1'b0;
                    rready  <= 1'b1;
                    state   <= R;
                end
                R: if (r_hs) begin
                    cnt <= cnt + 8'd1;
                    err <= err | beat_err;
                    if (done) begin
                        rready <= 1'b0;
                        state  <= IDLE;
                    end
                end
                WERR: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_22040632_imif_axi_rd_bridge.sv
// tb_ysyx_22040632_imif_axi_rd_bridge: directed scenarios for the icache AXI read bridge
module tb_ysyx_22040632_imif_axi_rd_bridge;
    localparam logic [3:0] ID = 4'd0;
    logic clk = 1'b0;
    logic rrst_n = 1'b0;
    always #5 clk = ~clk;
    ysyx_22040632_imif_if #(.ADDR_W(32), .DATA_W(64)) imif();
    ysyx_22040632_axi_rd_if #(.ADDR_W(32), .DATA_W(64)) axi();
    ysyx_22040632_imif_axi_rd_bridge #(.AXI_ID(ID), .ADDR_W(32), .DATA_W(64)) dut (
        .clk(clk), .rrst_n(rrst_n), .imif(imif), .axi(axi)
    );
    int n_checks = 0;
    int n_fail = 0;
    logic [63:0] got [0:15];
    int hs_n, last_n, ready_n, done_at, ar_first;
    logic done_err, ar_unstable, timed_out, post_ready, post_rready, post_arvalid;
    logic [31:0] ar_addr;
    logic [7:0] ar_len;
    logic [2:0] ar_size;
    logic [1:0] ar_burst;
    logic [3:0] ar_id;

    // Acts as both icache and AXI slave; records what the DUT did, never decides pass/fail.
    task automatic do_read(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                           input logic [63:0] base, input int ar_wait, input bit gappy,
                           input int bad_beat, input int last_beat, input int stop_after);
        int cyc = 0;
        int beat = 0;
        int waited = 0;
        bit ar_ok = 0;
        bit ph = 1;
        bit hs_now;
        hs_n = 0; last_n = 0; ready_n = 0; done_at = -1; done_err = 0;
        ar_first = -1; ar_unstable = 0;
        @(negedge clk);
        imif.rw_valid = 1; imif.rw_req = 0; imif.rw_addr = a; imif.rw_len = l; imif.rw_size = s;
        axi.arready = 0; axi.rvalid = 0;
        while (done_at < 0 && beat < stop_after && cyc < 300) begin
            if (cyc > 0) begin
                @(negedge clk);
                imif.rw_addr = ~a; imif.rw_len = 8'hA5; imif.rw_size = 3'd1;
            end
            hs_now = 0;
            if (axi.arvalid) begin
                if (ar_first < 0) begin
                    ar_first = cyc; ar_addr = axi.araddr; ar_len = axi.arlen;
                    ar_size = axi.arsize; ar_burst = axi.arburst; ar_id = axi.arid;
                end else if (axi.araddr !== ar_addr || axi.arlen !== ar_len) ar_unstable = 1;
                axi.arready = waited >= ar_wait;
                hs_now = axi.arready;
                waited++;
            end else axi.arready = 0;
            axi.rvalid = ar_ok && (!gappy || ph);
            if (ar_ok) ph = ~ph;
            axi.rdata = base + 64'(beat);
            axi.rresp = beat == bad_beat ? 2'b10 : 2'b00;
            axi.rlast = last_beat >= 0 ? beat == last_beat : beat == int'(l);
            axi.rid = ID;
            #1;
            if (imif.r_hs) begin
                if (beat < 16) got[beat] = imif.data_read;
                beat++; hs_n++;
            end
            if (imif.r_last) last_n++;
            if (imif.rw_ready) begin ready_n++; done_at = beat; done_err = imif.rw_err; end
            ar_ok = ar_ok | hs_now;
            cyc++;
        end
        timed_out = cyc >= 300;
        if (beat >= stop_after && done_at < 0) return;
        @(negedge clk);
        imif.rw_valid = 0; axi.arready = 0; axi.rvalid = 0; axi.rlast = 0;
        #1;
        post_ready = imif.rw_ready; post_rready = axi.rready; post_arvalid = axi.arvalid;
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (axi.arvalid !== 1'b0) begin n_fail++; $display("FAIL rst_arvalid got %b want 0", axi.arvalid); end
        n_checks++; if (axi.rready !== 1'b0) begin n_fail++; $display("FAIL rst_rready got %b want 0", axi.rready); end
        n_checks++; if (imif.rw_ready !== 1'b0) begin n_fail++; $display("FAIL rst_rw_ready got %b want 0", imif.rw_ready); end
        n_checks++; if (imif.rw_err !== 1'b0) begin n_fail++; $display("FAIL rst_rw_err got %b want 0", imif.rw_err); end
        n_checks++; if (imif.r_hs !== 1'b0 || imif.r_last !== 1'b0) begin n_fail++; $display("FAIL rst_hs_last got %b%b want 00", imif.r_hs, imif.r_last); end
        n_checks++; if (imif.data_read !== 64'd0) begin n_fail++; $display("FAIL rst_data got %h want 0", imif.data_read); end
        n_checks++; if (axi.araddr !== 32'd0 || axi.arlen !== 8'd0 || axi.arsize !== 3'd0) begin n_fail++; $display("FAIL rst_ar_latch got %h/%0d/%0d want 0/0/0", axi.araddr, axi.arlen, axi.arsize); end
        n_checks++; if (axi.arburst !== 2'b01 || axi.arid !== ID) begin n_fail++; $display("FAIL rst_burst_id got %b/%h want 01/%h", axi.arburst, axi.arid, ID); end
        @(negedge clk); rrst_n = 1;
    endtask

    task automatic test_cached_burst();
        logic [63:0] base = 64'h1111_2222_3333_4000;
        do_read(32'h8000_0040, 8'd7, 3'd3, base, 0, 0, -1, -1, 99);
        n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL burst_timeout got %b want 0", timed_out); end
        n_checks++; if (ar_first !== 1) begin n_fail++; $display("FAIL burst_accept_lat got %0d want 1", ar_first); end
        n_checks++; if (ar_addr !== 32'h8000_0040) begin n_fail++; $display("FAIL burst_araddr got %h want 80000040", ar_addr); end
        n_checks++; if (ar_len !== 8'd7 || ar_size !== 3'd3) begin n_fail++; $display("FAIL burst_len_size got %0d/%0d want 7/3", ar_len, ar_size); end
        n_checks++; if (ar_burst !== 2'b01 || ar_id !== ID) begin n_fail++; $display("FAIL burst_type_id got %b/%h want 01/%h", ar_burst, ar_id, ID); end
        n_checks++; if (hs_n !== 8) begin n_fail++; $display("FAIL burst_hs got %0d want 8", hs_n); end
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (got[i] !== base + 64'(i)) begin n_fail++; $display("FAIL burst_data%0d got %h want %h", i, got[i], base + 64'(i)); end
        end
        n_checks++; if (last_n !== 1 || ready_n !== 1 || done_at !== 8) begin n_fail++; $display("FAIL burst_done got last=%0d ready=%0d at=%0d want 1/1/8", last_n, ready_n, done_at); end
        n_checks++; if (done_err !== 1'b0) begin n_fail++; $display("FAIL burst_err got %b want 0", done_err); end
        n_checks++; if (post_ready !== 1'b0 || post_rready !== 1'b0 || post_arvalid !== 1'b0) begin n_fail++; $display("FAIL burst_after got ready=%b rready=%b arvalid=%b want 000", post_ready, post_rready, post_arvalid); end
    endtask

    task automatic test_uncached();
        do_read(32'h8000_0004, 8'd0, 3'd2, 64'h1234_5678_9ABC_DEF0, 0, 0, -1, -1, 99);
        n_checks++; if (got[0] !== 64'h0000_0000_1234_5678) begin n_fail++; $display("FAIL unc_data got %h want 0000000012345678", got[0]); end
        n_checks++; if (hs_n !== 1 || last_n !== 1 || ready_n !== 1 || done_at !== 1) begin n_fail++; $display("FAIL unc_done got hs=%0d last=%0d ready=%0d at=%0d want 1/1/1/1", hs_n, last_n, ready_n, done_at); end
        n_checks++; if (ar_len !== 8'd0 || ar_size !== 3'd2 || ar_addr !== 32'h8000_0004) begin n_fail++; $display("FAIL unc_ar got %h/%0d/%0d want 80000004/0/2", ar_addr, ar_len, ar_size); end
        n_checks++; if (done_err !== 1'b0) begin n_fail++; $display("FAIL unc_err got %b want 0", done_err); end
    endtask

    task automatic test_backpressure();
        logic [63:0] base = 64'hCAFE_0000_0000_0100;
        do_read(32'h8000_0080, 8'd7, 3'd3, base, 5, 1, -1, -1, 99);
        n_checks++; if (ar_unstable !== 1'b0 || ar_addr !== 32'h8000_0080) begin n_fail++; $display("FAIL bp_ar_stable got unstable=%b addr=%h want 0/80000080", ar_unstable, ar_addr); end
        n_checks++; if (hs_n !== 8 || done_at !== 8 || ready_n !== 1) begin n_fail++; $display("FAIL bp_done got hs=%0d at=%0d ready=%0d want 8/8/1", hs_n, done_at, ready_n); end
        n_checks++; if (got[7] !== base + 64'd7 || got[3] !== base + 64'd3) begin n_fail++; $display("FAIL bp_data got %h %h want %h %h", got[3], got[7], base + 64'd3, base + 64'd7); end
        n_checks++; if (done_err !== 1'b0 || timed_out !== 1'b0) begin n_fail++; $display("FAIL bp_err got err=%b to=%b want 0/0", done_err, timed_out); end
    endtask

    task automatic test_errors();
        do_read(32'h8000_0100, 8'd7, 3'd3, 64'h0, 0, 0, 2, -1, 99);
        n_checks++; if (hs_n !== 8 || done_at !== 8) begin n_fail++; $display("FAIL resp_beats got hs=%0d at=%0d want 8/8", hs_n, done_at); end
        n_checks++; if (done_err !== 1'b1) begin n_fail++; $display("FAIL resp_err got %b want 1", done_err); end
        do_read(32'h8000_0140, 8'd7, 3'd3, 64'h0, 0, 0, -1, 4, 99);
        n_checks++; if (hs_n !== 5 || done_at !== 5 || last_n !== 1) begin n_fail++; $display("FAIL early_last got hs=%0d at=%0d last=%0d want 5/5/1", hs_n, done_at, last_n); end
        n_checks++; if (done_err !== 1'b1) begin n_fail++; $display("FAIL early_err got %b want 1", done_err); end
        do_read(32'h8000_0180, 8'd3, 3'd3, 64'h0, 0, 0, -1, 9, 99);
        n_checks++; if (hs_n !== 4 || done_at !== 4) begin n_fail++; $display("FAIL missing_last got hs=%0d at=%0d want 4/4", hs_n, done_at); end
        n_checks++; if (done_err !== 1'b1) begin n_fail++; $display("FAIL missing_err got %b want 1", done_err); end
        do_read(32'h8000_01C0, 8'd1, 3'd3, 64'h0, 0, 0, -1, -1, 99);
        n_checks++; if (done_err !== 1'b0 || done_at !== 2) begin n_fail++; $display("FAIL err_cleared got err=%b at=%0d want 0/2", done_err, done_at); end
    endtask

    task automatic test_write();
        @(negedge clk);
        imif.rw_valid = 1; imif.rw_req = 1; imif.rw_addr = 32'h8000_0200;
        #1;
        n_checks++; if (imif.rw_ready !== 1'b0 || axi.arvalid !== 1'b0) begin n_fail++; $display("FAIL wr_c0 got ready=%b arvalid=%b want 00", imif.rw_ready, axi.arvalid); end
        @(negedge clk);
        #1;
        n_checks++; if (imif.rw_ready !== 1'b1 || imif.rw_err !== 1'b1) begin n_fail++; $display("FAIL wr_c1 got ready=%b err=%b want 11", imif.rw_ready, imif.rw_err); end
        n_checks++; if (axi.arvalid !== 1'b0) begin n_fail++; $display("FAIL wr_no_ar got %b want 0", axi.arvalid); end
        imif.rw_valid = 0; imif.rw_req = 0;
        @(negedge clk);
        #1;
        n_checks++; if (imif.rw_ready !== 1'b0 || imif.rw_err !== 1'b0 || axi.arvalid !== 1'b0) begin n_fail++; $display("FAIL wr_c2 got ready=%b err=%b arvalid=%b want 000", imif.rw_ready, imif.rw_err, axi.arvalid); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] base = 64'h5555_0000_0000_0010;
        do_read(32'h8000_0300, 8'd7, 3'd3, base, 0, 0, -1, -1, 4);
        @(negedge clk);
        axi.rvalid = 1; axi.rdata = 64'hDEAD_BEEF_DEAD_BEEF; axi.rlast = 1;
        rrst_n = 0;
        #1;
        n_checks++; if (axi.arvalid !== 1'b0 || axi.rready !== 1'b0) begin n_fail++; $display("FAIL rmid_axi got arvalid=%b rready=%b want 00", axi.arvalid, axi.rready); end
        n_checks++; if (imif.r_hs !== 1'b0 || imif.r_last !== 1'b0 || imif.rw_ready !== 1'b0 || imif.rw_err !== 1'b0) begin n_fail++; $display("FAIL rmid_req got hs=%b last=%b ready=%b err=%b want 0000", imif.r_hs, imif.r_last, imif.rw_ready, imif.rw_err); end
        n_checks++; if (imif.data_read !== 64'd0) begin n_fail++; $display("FAIL rmid_data got %h want 0", imif.data_read); end
        imif.rw_valid = 0; axi.rvalid = 0; axi.rlast = 0;
        @(negedge clk); rrst_n = 1;
        do_read(32'h8000_0340, 8'd7, 3'd3, base, 0, 0, -1, -1, 99);
        n_checks++; if (hs_n !== 8 || done_at !== 8 || done_err !== 1'b0) begin n_fail++; $display("FAIL rmid_after got hs=%0d at=%0d err=%b want 8/8/0", hs_n, done_at, done_err); end
        n_checks++; if (got[0] !== base || got[7] !== base + 64'd7) begin n_fail++; $display("FAIL rmid_after_data got %h %h want %h %h", got[0], got[7], base, base + 64'd7); end
    endtask

    task automatic test_back_to_back();
        do_read(32'h8000_0400, 8'd1, 3'd3, 64'h100, 0, 0, -1, -1, 99);
        n_checks++; if (done_at !== 2 || done_err !== 1'b0) begin n_fail++; $display("FAIL b2b_first got at=%0d err=%b want 2/0", done_at, done_err); end
        do_read(32'h8000_0006, 8'd0, 3'd1, 64'h0000_0000_ABCD_0000, 0, 0, -1, -1, 99);
        n_checks++; if (ar_first !== 1 || ar_addr !== 32'h8000_0006) begin n_fail++; $display("FAIL b2b_accept got lat=%0d addr=%h want 1/80000006", ar_first, ar_addr); end
        n_checks++; if (got[0] !== 64'h0000_0000_0000_0000 || done_at !== 1) begin n_fail++; $display("FAIL b2b_data got %h at=%0d want 0/1", got[0], done_at); end
        do_read(32'h8000_0002, 8'd0, 3'd1, 64'h0000_0000_ABCD_0000, 0, 0, -1, -1, 99);
        n_checks++; if (got[0] !== 64'h0000_0000_0000_ABCD) begin n_fail++; $display("FAIL b2b_half got %h want 000000000000abcd", got[0]); end
    endtask

    initial begin
        imif.rw_valid = 0; imif.rw_req = 0; imif.rw_addr = 0; imif.rw_len = 0; imif.rw_size = 0;
        axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 0; axi.rid = ID;
        test_reset();
        test_cached_burst();
        test_uncached();
        test_backpressure();
        test_errors();
        test_write();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
